// File: rtl/sobel_pkg.sv
// Shared constants, FSM encoding and 3x3 window helpers for the Sobel frame sequencer.
// Windows are row-major 72-bit words: mat00 in [71:64], mat22 (newest pixel) in [7:0].
package sobel_pkg;

  localparam int PIX_W     = 8;
  localparam int WIN_W     = 72;
  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  function automatic logic [PIX_W-1:0] win_get(input logic [WIN_W-1:0] w, input int r, input int c);
    return w[WIN_W-1-PIX_W*(3*r+c) -: PIX_W];
  endfunction

  function automatic logic [WIN_W-1:0] win_put(input logic [WIN_W-1:0] w, input int r, input int c,
                                               input logic [PIX_W-1:0] p);
    logic [WIN_W-1:0] o;
    o = w;
    o[WIN_W-1-PIX_W*(3*r+c) -: PIX_W] = p;
    return o;
  endfunction

  // Columns move left by one; the new right column is {top, mid, bot}.
  function automatic logic [WIN_W-1:0] win_shift(input logic [WIN_W-1:0] w, input logic [PIX_W-1:0] top,
                                                 input logic [PIX_W-1:0] mid, input logic [PIX_W-1:0] bot);
    logic [WIN_W-1:0] o;
    o = w;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        o = win_put(o, r, c, win_get(w, r, c + 1));
      end
    end
    o = win_put(o, 0, 2, top);
    o = win_put(o, 1, 2, mid);
    o = win_put(o, 2, 2, bot);
    return o;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// DEPTH-deep pixel delay line advanced only on en; dout is the sample pushed DEPTH enables ago.
// The output register prefetches the next slot so it is ready before the following enable.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [PIX_W-1:0] dout_q;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

  // Reads the slot after the one being written, so read and write never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      dout_q <= '0;
    end else if (en) begin
      ptr_q  <= ptr_d;
      dout_q <= mem[ptr_d];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Raster-scan frame sequencer: builds 3x3 windows for an external Sobel core and emits
// interior edge decisions with their centre coordinates, then pulses done.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int XW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [WIN_W-1:0] window_o,
  input  logic             edge_i,
  output logic             edge_o,
  output logic             edge_valid,
  output logic [XW-1:0]    edge_x,
  output logic [XW-1:0]    edge_y
);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic [XW-1:0]    win_x_q, win_x_d, win_y_q, win_y_d;
  logic             edge_o_q, edge_o_d, edge_valid_q, edge_valid_d;
  logic [XW-1:0]    edge_x_q, edge_x_d, edge_y_q, edge_y_d;
  logic             busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic             accept;
  logic [1:0][PIX_W-1:0] lb_din, lb_dout;

  assign accept    = pix_in_valid && ready_q;
  assign lb_din[0] = pix_in;
  assign lb_din[1] = lb_dout[0];

  // Index 0 holds the previous row, index 1 the row before that.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    sobel_line_buffer #(.DEPTH(IMG_W)) u_lb (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .din  (lb_din[gi]),
      .dout (lb_dout[gi])
    );
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    edge_o_d     = edge_o_q;
    edge_valid_d = win_valid_q;
    edge_x_d     = edge_x_q;
    edge_y_d     = edge_y_q;
    done_d       = 1'b0;
    if (win_valid_q) begin
      edge_o_d = edge_i;
      edge_x_d = win_x_q;
      edge_y_d = win_y_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_STREAM;
          x_d          = '0;
          y_d          = '0;
          edge_valid_d = 1'b0;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          win_d       = win_shift(win_q, lb_dout[1], lb_dout[0], pix_in);
          win_valid_d = (x_q >= XW'(2)) && (y_q >= XW'(2));
          win_x_d     = x_q - XW'(1);
          win_y_d     = y_q - XW'(1);
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q == XW'(IMG_H - 1)) begin
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + XW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The bottom-right interior centre is always the last result of a frame.
        if (edge_valid_q && edge_x_q == XW'(IMG_W - 2) && edge_y_q == XW'(IMG_H - 2)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      edge_o_q     <= 1'b0;
      edge_valid_q <= 1'b0;
      edge_x_q     <= '0;
      edge_y_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      edge_o_q     <= edge_o_d;
      edge_valid_q <= edge_valid_d;
      edge_x_q     <= edge_x_d;
      edge_y_q     <= edge_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pix_in_ready = ready_q;
  assign window_o     = win_q;
  assign edge_o       = edge_o_q;
  assign edge_valid   = edge_valid_q;
  assign edge_x       = edge_x_q;
  assign edge_y       = edge_y_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench: an 8x8 instance and a 3x3 instance, each with a stub core that flags
// an edge when the centre pixel MSB is set.
module tb_sobel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start3 = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_in_valid = 1'b0;

  logic        busy8, done8, ready8, eo8, ev8, edge_i8;
  logic [71:0] win8;
  logic [15:0] ex8, ey8;
  logic        busy3, done3, ready3, eo3, ev3, edge_i3;
  logic [71:0] win3;
  logic [15:0] ex3, ey3;

  assign edge_i8 = win8[39];
  assign edge_i3 = win3[39];

  sobel_frame_ctrl #(.IMG_W(8), .IMG_H(8), .XW(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(ready8),
    .window_o(win8), .edge_i(edge_i8), .edge_o(eo8), .edge_valid(ev8),
    .edge_x(ex8), .edge_y(ey8)
  );

  sobel_frame_ctrl #(.IMG_W(3), .IMG_H(3), .XW(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(ready3),
    .window_o(win3), .edge_i(edge_i3), .edge_o(eo3), .edge_valid(ev3),
    .edge_x(ex3), .edge_y(ey3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ev_x8[$], ev_y8[$], ev_e8[$], ev_c8[$], acc_c8[$], done_c8[$], done_b8[$];
  int ev_x3[$], ev_y3[$], ev_e3[$], ev_c3[$], acc_c3[$], done_c3[$], done_b3[$];

  always @(negedge clk) begin
    if (ev8 === 1'b1) begin
      ev_x8.push_back(int'(ex8)); ev_y8.push_back(int'(ey8));
      ev_e8.push_back(int'(eo8)); ev_c8.push_back(cyc);
    end
    if (pix_in_valid && ready8 === 1'b1) acc_c8.push_back(cyc);
    if (done8 === 1'b1) begin done_c8.push_back(cyc); done_b8.push_back(int'(busy8)); end
    if (ev3 === 1'b1) begin
      ev_x3.push_back(int'(ex3)); ev_y3.push_back(int'(ey3));
      ev_e3.push_back(int'(eo3)); ev_c3.push_back(cyc);
    end
    if (pix_in_valid && ready3 === 1'b1) acc_c3.push_back(cyc);
    if (done3 === 1'b1) begin done_c3.push_back(cyc); done_b3.push_back(int'(busy3)); end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] img [0:63];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [71:0] obs);
    n_chk++;
    assert (obs === 72'd0) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=0", tag, obs);
    end
  endtask

  task automatic start_frame(input bit sel);
    @(posedge clk); #1;
    if (sel) start3 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; start8 = 1'b0;
    chk(sel ? "busy3_after_start" : "busy8_after_start", int'(sel ? busy3 : busy8), 1);
  endtask

  task automatic stream(input bit sel, input int n, input bit gaps, input int restart_at);
    int k = 0;
    int guard = 0;
    bit pulsed = 1'b0;
    logic rdy;
    while (k < n && guard < 4000) begin
      pix_in = img[k];
      pix_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start8 = (!pulsed && k == restart_at);
      if (start8) pulsed = 1'b1;
      @(negedge clk);
      rdy = sel ? ready3 : ready8;
      if (pix_in_valid && rdy === 1'b1) k++;
      @(posedge clk); #1;
      guard++;
    end
    pix_in_valid = 1'b0;
    start8 = 1'b0;
    chk("stream_accepts", k, n);
  endtask

  task automatic wait_done(input bit sel, input int base);
    int g = 0;
    while ((sel ? done_c3.size() : done_c8.size()) <= base && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", int'((sel ? done_c3.size() : done_c8.size()) > base), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_frame8(input string nm, input int eb, input int ab, input int db, input int exp_ones);
    int n, ones, ex, ey, ai;
    n = ev_x8.size() - eb;
    ones = 0;
    chk({nm, "_count"}, n, 36);
    for (int i = 0; i < n && i < 36; i++) begin
      ex = 1 + i % 6;
      ey = 1 + i / 6;
      ai = ab + (ey + 1) * 8 + (ex + 1);
      chk($sformatf("%s_x%0d", nm, i), ev_x8[eb+i], ex);
      chk($sformatf("%s_y%0d", nm, i), ev_y8[eb+i], ey);
      chk($sformatf("%s_e%0d", nm, i), ev_e8[eb+i], int'(img[ey*8+ex][7]));
      chk($sformatf("%s_lat%0d", nm, i), ev_c8[eb+i], (ai < acc_c8.size()) ? acc_c8[ai] + 2 : -1);
      ones += ev_e8[eb+i];
    end
    chk({nm, "_ones"}, ones, exp_ones);
    chk({nm, "_done_pulses"}, done_c8.size() - db, 1);
    if (done_c8.size() > db && n > 0) begin
      chk({nm, "_done_cycle"}, done_c8[db], ev_c8[ev_c8.size()-1] + 1);
      chk({nm, "_busy_at_done"}, done_b8[db], 0);
    end
    chk({nm, "_busy_after"}, int'(busy8), 0);
    chk({nm, "_ready_after"}, int'(ready8), 0);
  endtask

  task automatic run8(input string nm, input bit gaps, input int restart_at, input int exp_ones);
    int eb, ab, db;
    eb = ev_x8.size(); ab = acc_c8.size(); db = done_c8.size();
    start_frame(1'b0);
    stream(1'b0, 64, gaps, restart_at);
    wait_done(1'b0, db);
    check_frame8(nm, eb, ab, db, exp_ones);
  endtask

  task automatic img_flat();
    for (int i = 0; i < 64; i++) img[i] = 8'd50;
  endtask

  task automatic img_dot();
    for (int i = 0; i < 64; i++) img[i] = 8'd0;
    img[5*8+3] = 8'd200;
  endtask

  initial begin
    int nb, eb, ab, db;
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_ready", int'(ready8), 0);
    chk("rst_edge_o", int'(eo8), 0);
    chk("rst_edge_valid", int'(ev8), 0);
    chk("rst_edge_x", int'(ex8), 0);
    chk("rst_edge_y", int'(ey8), 0);
    chk_win("rst_window", win8);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    img_flat();
    run8("flat", 1'b0, -1, 0);

    img_dot();
    run8("dot", 1'b0, -1, 1);

    run8("dot_gaps", 1'b1, -1, 1);

    img_flat();
    run8("restart_ignored", 1'b0, 10, 0);
    img_dot();
    run8("second_frame", 1'b0, -1, 1);

    img_flat();
    start_frame(1'b0);
    stream(1'b0, 20, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_ready", int'(ready8), 0);
    chk("abort_done", int'(done8), 0);
    chk("abort_edge_valid", int'(ev8), 0);
    chk("abort_edge_o", int'(eo8), 0);
    chk("abort_edge_x", int'(ex8), 0);
    chk("abort_edge_y", int'(ey8), 0);
    chk_win("abort_window", win8);
    nb = ev_x8.size();
    db = done_c8.size();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_late_results", ev_x8.size(), nb);
    chk("abort_no_done", done_c8.size(), db);
    chk("abort_idle_ready", int'(ready8), 0);
    img_dot();
    run8("after_abort", 1'b0, -1, 1);

    for (int i = 0; i < 9; i++) img[i] = 8'd0;
    img[4] = 8'h80;
    eb = ev_x3.size(); ab = acc_c3.size(); db = done_c3.size();
    start_frame(1'b1);
    stream(1'b1, 9, 1'b0, -1);
    wait_done(1'b1, db);
    chk("min_count", ev_x3.size() - eb, 1);
    if (ev_x3.size() > eb && acc_c3.size() > ab + 8) begin
      chk("min_x", ev_x3[eb], 1);
      chk("min_y", ev_y3[eb], 1);
      chk("min_edge", ev_e3[eb], 1);
      chk("min_latency", ev_c3[eb], acc_c3[ab+8] + 2);
      if (done_c3.size() > db) begin
        chk("min_done_cycle", done_c3[db], ev_c3[eb] + 1);
        chk("min_busy_at_done", done_b3[db], 0);
      end
    end
    chk("min_done_pulses", done_c3.size() - db, 1);
    chk("min_busy_after", int'(busy3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
